// File: rtl/paddle_input_conditioner.sv
// Button front end for the breakout game: synchronises, debounces and
// arbitrates the raw left/right/restart push-buttons, stretches restart into
// a fixed-width pulse, and locks movement out after a restart until both
// move buttons have been released.
module paddle_input_conditioner #(
    parameter int DB_CYCLES   = 500000,
    parameter int CNT_W       = 19,
    parameter int RESTART_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic btn_restart_n,
    output logic to_left,
    output logic to_right,
    output logic restart,
    output logic busy
);

    localparam int PC_W = $clog2(RESTART_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_REL
    } state_t;

    // Channel index: 0 = left, 1 = right, 2 = restart.
    logic [2:0]       sync_1;
    logic [2:0]       sync_2;
    logic [2:0]       s_btn;
    logic [2:0]       d_btn;
    logic [CNT_W-1:0] db_cnt [3];

    logic             d_left;
    logic             d_right;
    logic             d_rst;
    logic             d_rst_q;
    logic             rst_rise;
    logic             mv_l;
    logic             mv_r;

    state_t           state_q;
    state_t           next_state;
    logic [PC_W-1:0]  pcnt_q;
    logic [PC_W-1:0]  pcnt_d;

    // Two-flop synchronisers; they reset to the released (high) pin level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            // NOTE: non-blocking assignments let sync_2 take the old sync_1,
            // forming a real two-stage chain; blocking would collapse it.
            sync_1 <= {btn_restart_n, btn_right_n, btn_left_n};
            sync_2 <= sync_1;
        end
    end

    assign s_btn = ~sync_2;

    // Per-channel debounce: flip the debounced state only after DB_CYCLES
    // consecutive cycles of disagreement; counters clear at the flip.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_btn <= '0;
            // NOTE: the counter array is three plain registers, not a RAM,
            // so it is safe and required to clear it in the reset branch.
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_btn[i] == d_btn[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    d_btn[i]  <= s_btn[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign d_left  = d_btn[0];
    assign d_right = d_btn[1];
    assign d_rst   = d_btn[2];

    // Delayed restart level for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_rst_q <= 1'b0;
        else          d_rst_q <= d_rst;
    end

    assign rst_rise = d_rst & ~d_rst_q;

    // Both directions held cancels out to no movement.
    assign mv_l = d_left & ~d_right;
    assign mv_r = d_right & ~d_left;

    // FSM state and pulse counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
        end else begin
            state_q <= next_state;
            pcnt_q  <= pcnt_d;
        end
    end

    // Next-state logic: a pulse cannot be retriggered, but a new restart in
    // WAIT_REL starts another one.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no
        // latch is inferred.
        next_state = state_q;
        pcnt_d     = pcnt_q;
        case (state_q)
            IDLE: begin
                if (rst_rise) begin
                    next_state = PULSE;
                    pcnt_d     = PC_W'(RESTART_LEN - 1);
                end
            end
            PULSE: begin
                if (pcnt_q == '0) next_state = WAIT_REL;
                else              pcnt_d     = pcnt_q - PC_W'(1);
            end
            WAIT_REL: begin
                if (rst_rise) begin
                    next_state = PULSE;
                    pcnt_d     = PC_W'(RESTART_LEN - 1);
                end else if (!d_left && !d_right) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs; a restart edge in IDLE masks movement on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_left  <= 1'b0;
            to_right <= 1'b0;
            restart  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            to_left  <= mv_l & (state_q == IDLE) & ~rst_rise;
            to_right <= mv_r & (state_q == IDLE) & ~rst_rise;
            restart  <= (next_state == PULSE);
            busy     <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench for paddle_input_conditioner: directed scenarios followed by random
// button activity, every cycle compared against a behavioural model that
// works from button sample history and pulse/lockout bookkeeping.
module tb_paddle_input_conditioner;

    localparam int DB = 16;
    localparam int CW = 5;
    localparam int RL = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_left_n;
    logic btn_right_n;
    logic btn_restart_n;
    logic to_left;
    logic to_right;
    logic restart;
    logic busy;

    always #5 clk = ~clk;

    paddle_input_conditioner #(
        .DB_CYCLES  (DB),
        .CNT_W      (CW),
        .RESTART_LEN(RL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_left_n   (btn_left_n),
        .btn_right_n  (btn_right_n),
        .btn_restart_n(btn_restart_n),
        .to_left      (to_left),
        .to_right     (to_right),
        .restart      (restart),
        .busy         (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pin samples of the last two edges, per-channel history
    // of synchronised samples, debounced levels, and pulse/lockout status.
    logic [2:0]    m_ph0;
    logic [2:0]    m_ph1;
    logic [DB-1:0] m_sh [3];
    logic [2:0]    m_d;
    logic          m_drq;
    int            m_pulse_edges;
    bit            m_locked;
    logic          m_left;
    logic          m_right;
    logic          m_restart;
    logic          m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph0 = '0;
        m_ph1 = '0;
        for (int c = 0; c < 3; c++) m_sh[c] = '0;
        m_d           = '0;
        m_drq         = 1'b0;
        m_pulse_edges = 0;
        m_locked      = 1'b0;
        m_left        = 1'b0;
        m_right       = 1'b0;
        m_restart     = 1'b0;
        m_busy        = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, using pre-edge values.
    function automatic void model_edge();
        logic [2:0] s;
        logic       dl, dr, rise, idle;
        s     = m_ph1;
        m_ph1 = m_ph0;
        m_ph0 = ~{btn_restart_n, btn_right_n, btn_left_n};
        dl    = m_d[0];
        dr    = m_d[1];
        rise  = m_d[2] & ~m_drq;
        idle  = (m_pulse_edges == 0) && !m_locked;

        m_left  = idle && !rise && dl && !dr;
        m_right = idle && !rise && dr && !dl;

        // A pulse occupies RL edges; new restart edges are ignored meanwhile.
        if (m_pulse_edges > 0) begin
            m_pulse_edges--;
        end else if (rise) begin
            m_pulse_edges = RL;
            m_locked      = 1'b1;
        end else if (m_locked && !dl && !dr) begin
            m_locked = 1'b0;
        end
        m_restart = (m_pulse_edges > 0);
        m_busy    = (m_pulse_edges > 0) || m_locked;

        m_drq = m_d[2];
        // Debounced level follows once the last DB samples all disagree.
        for (int c = 0; c < 3; c++) begin
            m_sh[c] = {m_sh[c][DB-2:0], s[c]};
            if (m_sh[c] == {DB{~m_d[c]}}) m_d[c] = ~m_d[c];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        #1;
        check("to_left",  to_left,  m_left);
        check("to_right", to_right, m_right);
        check("restart",  restart,  m_restart);
        check("busy",     busy,     m_busy);
    endtask

    function automatic logic out_sel(input int sel);
        case (sel)
            0:       return to_left;
            1:       return to_right;
            2:       return restart;
            default: return busy;
        endcase
    endfunction

    // Tick until the selected output reaches val; n = edges taken, -1 if not.
    task automatic wait_out(input int sel, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (out_sel(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int n;
        int cnt;
        bit seen;

        reset_n       = 1'b0;
        btn_left_n    = 1'b1;
        btn_right_n   = 1'b1;
        btn_restart_n = 1'b1;
        model_reset();
        #3;
        check("rst_left",    to_left,  1'b0);
        check("rst_right",   to_right, 1'b0);
        check("rst_restart", restart,  1'b0);
        check("rst_busy",    busy,     1'b0);
        idle_ticks(2);
        reset_n = 1'b1;
        idle_ticks(3);

        // Clean left press and release.
        btn_left_n = 1'b0;
        wait_out(0, 1'b1, 40, n);
        check("left_press_latency", (n >= 18 && n <= 20), 1'b1);
        idle_ticks(10);
        check("left_held", to_left, 1'b1);
        btn_left_n = 1'b1;
        wait_out(0, 1'b0, 40, n);
        check("left_release_latency", (n >= 18 && n <= 20), 1'b1);
        idle_ticks(5);

        // Short right glitches never get through.
        seen = 1'b0;
        for (int p = 0; p < 5; p++) begin
            btn_right_n = 1'b0;
            for (int i = 0; i < 10; i++) begin tick(); seen |= to_right; end
            btn_right_n = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(); seen |= to_right; end
        end
        for (int i = 0; i < 20; i++) begin tick(); seen |= to_right; end
        check("glitch_right_seen", seen, 1'b0);

        // Both held cancels; releasing left leaves right.
        btn_left_n  = 1'b0;
        btn_right_n = 1'b0;
        idle_ticks(25);
        check("both_left",  to_left,  1'b0);
        check("both_right", to_right, 1'b0);
        btn_left_n = 1'b1;
        wait_out(1, 1'b1, 40, n);
        check("right_after_left_release", (n >= 18 && n <= 20), 1'b1);
        btn_right_n = 1'b1;
        idle_ticks(25);

        // Restart while moving left: pulse, lockout, release.
        btn_left_n = 1'b0;
        wait_out(0, 1'b1, 40, n);
        check("left_before_restart", n > 0, 1'b1);
        btn_restart_n = 1'b0;
        wait_out(2, 1'b1, 40, n);
        check("restart_seen",     n > 0,   1'b1);
        check("left_at_rst_rise", to_left, 1'b0);
        check("busy_at_rst_rise", busy,    1'b1);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (restart === 1'b1) cnt++;
            else break;
        end
        check("pulse_width_1", cnt, 4);
        btn_restart_n = 1'b1;
        idle_ticks(30);
        check("locked_left", to_left, 1'b0);
        check("locked_busy", busy,    1'b1);
        btn_left_n = 1'b1;
        idle_ticks(25);
        check("unlock_busy", busy,    1'b0);
        check("unlock_left", to_left, 1'b0);

        // Second press inside the pulse is ignored; another press in WAIT_REL
        // gives a fresh pulse. Left is held to stay in WAIT_REL.
        btn_left_n = 1'b0;
        idle_ticks(25);
        btn_restart_n = 1'b0;
        wait_out(2, 1'b1, 40, n);
        check("restart2_seen", n > 0, 1'b1);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) btn_restart_n = 1'b1;
            if (i == 1) btn_restart_n = 1'b0;
            if (restart === 1'b1) cnt++;
            else break;
        end
        check("pulse_width_retrigger", cnt, 4);
        btn_restart_n = 1'b1;
        idle_ticks(30);
        check("wait_rel_busy", busy, 1'b1);
        btn_restart_n = 1'b0;
        wait_out(2, 1'b1, 40, n);
        check("restart3_seen", n > 0, 1'b1);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (restart === 1'b1) cnt++;
            else break;
        end
        check("pulse_width_wait_rel", cnt, 4);
        btn_restart_n = 1'b1;
        btn_left_n    = 1'b1;
        idle_ticks(30);
        check("after_second_pulse_busy", busy, 1'b0);

        // Reset during the second cycle of a restart pulse.
        btn_restart_n = 1'b0;
        wait_out(2, 1'b1, 40, n);
        check("restart4_seen", n > 0, 1'b1);
        tick();
        check("pulse_cycle2", restart, 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_restart", restart,  1'b0);
        check("midrst_busy",    busy,     1'b0);
        check("midrst_left",    to_left,  1'b0);
        check("midrst_right",   to_right, 1'b0);
        btn_restart_n = 1'b1;
        idle_ticks(3);
        reset_n = 1'b1;
        idle_ticks(40);
        check("post_rst_restart", restart, 1'b0);
        check("post_rst_busy",    busy,    1'b0);

        // Random button activity with occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            int pins;
            pins          = $urandom_range(0, 7);
            btn_left_n    = pins[0];
            btn_right_n   = pins[1];
            btn_restart_n = pins[2];
            len           = $urandom_range(1, 40);
            if ($urandom_range(0, 24) == 0) begin
                reset_n = 1'b0;
                model_reset();
                idle_ticks(2);
                reset_n = 1'b1;
            end
            idle_ticks(len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
- Conditions the raw board push-buttons for the breakout game: left, right and restart.
- Sits directly upstream of the HDMI kernel and drives its to_left, to_right and restart inputs.
- Synchronises, debounces and arbitrates the buttons, and generates a stretched restart pulse.
- Movement is locked out after a restart until the player releases both move buttons.

Parameters:
- DB_CYCLES, 500000, consecutive clk cycles a synchronised input must differ from its debounced state before that state flips (10 ms at 50 MHz); must be >= 2.
- CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES.
- RESTART_LEN, 4, width of the restart output pulse in clk cycles; must be >= 2 so the 25 MHz pixel domain samples it.

Ports:
- clk  in  1  50 MHz system clock, the same clock that feeds the HDMI kernel.
- reset_n  in  1  reset, asynchronous, active-low.
- btn_left_n  in  1  raw left button, active-low, asynchronous to clk.
- btn_right_n  in  1  raw right button, active-low, asynchronous to clk.
- btn_restart_n  in  1  raw restart button, active-low, asynchronous to clk.
- to_left  out  1  registered level: move the paddle left.
- to_right  out  1  registered level: move the paddle right.
- restart  out  1  registered active-high pulse, RESTART_LEN cycles wide.
- busy  out  1  high while the FSM is not in IDLE (debug LED).

Behaviour:
- Reset, asynchronous:
  - All synchroniser flops load 1 (released).
  - Debounced states = 0, counters = 0, FSM = IDLE, pulse counter = 0.
  - to_left = to_right = restart = busy = 0.
- Synchroniser:
  - 2-flop chain per button.
  - The output is inverted to active-high: s_left, s_right, s_rst.
- Debounce, one instance per channel:
  - If s_x == d_x, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DB_CYCLES-1 while s_x != d_x: d_x <= s_x and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles causes no change.
  - Counters never wrap, because they clear at the terminal count.
- Arbitration, combinational, before the output register:
  - mv_l = d_left & ~d_right.
  - mv_r = d_right & ~d_left.
  - Both pressed gives neither direction.
- Restart edge: rst_rise = d_rst & ~d_rst_q, where d_rst_q is d_rst delayed by one cycle.
- FSM states:
  - IDLE: on rst_rise go to PULSE and load the pulse counter with RESTART_LEN-1.
  - PULSE: restart = 1. The counter decrements each cycle. When it reaches 0, go to WAIT_REL. rst_rise is ignored (non-retriggerable).
  - WAIT_REL: stay until d_left == 0 and d_right == 0, then go to IDLE. A rst_rise here goes to PULSE again.
- Outputs are registered:
  - to_left <= mv_l & (state == IDLE); to_right <= mv_r & (state == IDLE).
  - restart <= (next_state == PULSE).
  - busy <= (next_state != IDLE).
- Latency:
  - A clean press appears on to_left/to_right DB_CYCLES+3 cycles after the pin edge (2 sync + DB_CYCLES + 1 output register), ±1 cycle for synchroniser phase.
  - restart rises one cycle after d_rst rises.
- Simultaneous events: rst_rise in IDLE takes priority over movement; to_left and to_right are 0 on the same edge that restart rises.
- Reset mid-operation: reset forces the state to IDLE immediately, outputs drop asynchronously, and no pulse residue remains.
- Releasing the restart button has no effect on the outputs.

Test Plan (bench sets DB_CYCLES=16, CNT_W=5, RESTART_LEN=4):
- Hold btn_left_n=0 from t0 -> to_left=1 at t0+19 cycles (±1) and stays high; to_right=0 throughout; release -> to_left=0 after 19 (±1) cycles.
- btn_right_n pulses low for 10 cycles, 5 times with 3-cycle gaps -> to_right never asserts and the debounce counter never reaches 15.
- Hold both buttons pressed -> to_left=0 and to_right=0; release left only -> to_right=1 about 19 cycles later.
- Hold left, then press restart -> restart=1 for exactly 4 cycles; to_left=0 from the cycle restart rises; busy=1; to_left stays 0 while left is still held; release left -> busy=0 and to_left remains 0 until a new press.
- Press restart twice, with the second press landing inside the pulse -> a single 4-cycle pulse. Press restart again while still in WAIT_REL -> a second 4-cycle pulse.
- Assert reset_n=0 on the second cycle of a restart pulse -> restart, busy, to_left and to_right all 0 immediately. After release with no buttons pressed, all outputs stay 0.
